// File: rtl/joy_dir_filter.sv
`default_nettype none
// ============================================================================
// Module   : joy_dir_filter
// Purpose  : Per-player digital joystick direction filter placed between the
//            keyboard/gamepad merge and the core inputs. Each player channel
//            synchronises its raw directions, optionally debounces them,
//            remaps them for screen rotation, and cancels opposing directions.
//            It then applies a restrictor (8-way, 4-way latest-wins,
//            4-way first-wins, 2-way horizontal). The result is registered
//            together with a one-cycle change strobe.
// Config   : JOY_DIR_DEBOUNCE_EN - when defined, each synchronised bit passes
//            through a stability counter of DB_CYCLES cycles.
// Ports    : clk        - system clock (clk_sys domain)
//            reset_n    - asynchronous active-low reset
//            mode       - 00 8-way, 01 4-way latest-wins, 10 4-way first-wins,
//                         11 2-way horizontal
//            rotate     - 00 none, 01 90ccw, 10 180, 11 90cw
//            dis        - restrictor bypass (mask held at all-ones)
//            dir_in     - raw {up,down,left,right} per player, p at [4p+3:4p]
//            dir_out    - filtered directions, registered
//            dir_change - one-cycle pulse when a player's dir_out changes
// Revision : 1.0 - initial release
// ============================================================================
module joy_dir_filter #(
  parameter int PLAYERS     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             mode,
  input  logic [1:0]             rotate,
  input  logic                   dis,
  input  logic [4*PLAYERS-1:0]   dir_in,
  output logic [4*PLAYERS-1:0]   dir_out,
  output logic [PLAYERS-1:0]     dir_change
);

  // Highest-priority set bit as a one-hot vector, priority U > D > L > R.
  function automatic logic [3:0] f_first(input logic [3:0] v);
    logic [3:0] oh;
    oh = 4'b0000;
    if (v[3])      oh = 4'b1000;
    else if (v[2]) oh = 4'b0100;
    else if (v[1]) oh = 4'b0010;
    else if (v[0]) oh = 4'b0001;
    return oh;
  endfunction

  // Registered copies of the configuration; any difference flushes all
  // channels for one cycle so a stale mask never survives a mode/rotate swap.
  logic [1:0] r_mode;
  logic [1:0] r_rotate;
  logic       w_cfg_change;

  assign w_cfg_change = (mode != r_mode) || (rotate != r_rotate);

  // Reset release is expected to be synchronous to clk (handled upstream);
  // assertion is asynchronous.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode   <= 2'b00;
      r_rotate <= 2'b00;
    end else begin
      r_mode   <= mode;
      r_rotate <= rotate;
    end
  end

  // DB_CYCLES only sizes the debounce counters; this guard keeps it
  // referenced in builds without debounce.
  if (DB_CYCLES < 1) begin : g_db_range_guard
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [3:0] r_sync [SYNC_STAGES];
    logic [3:0] w_clean;
    logic [3:0] w_rot;
    logic [3:0] w_r;
    logic [3:0] w_edge;
    logic [3:0] w_mask_next;
    logic [3:0] w_out_next;
    logic [3:0] r_mask;
    logic [3:0] r_prev;
    logic [3:0] r_dir;
    logic       r_chg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'b0000;
      end else begin
        r_sync[0] <= dir_in[4*p +: 4];
        for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
    end

`ifdef JOY_DIR_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    // A bit is accepted only after DB_CYCLES consecutive cycles at a new
    // level; any return to the accepted level restarts the count.
    for (genvar b = 0; b < 4; b++) begin : g_bit
      logic [CNT_W-1:0] r_cnt;
      logic             r_db;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
          r_db  <= 1'b0;
        end else if (r_sync[SYNC_STAGES-1][b] == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
          r_db  <= r_sync[SYNC_STAGES-1][b];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_clean[b] = r_db;
    end
`else
    assign w_clean = r_sync[SYNC_STAGES-1];
`endif

    always_comb begin
      w_rot       = w_clean;
      w_mask_next = 4'b1111;
      w_out_next  = 4'b0000;

      // Rotation remap of {U,D,L,R}.
      case (rotate)
        2'b01:   w_rot = {w_clean[1], w_clean[0], w_clean[2], w_clean[3]};
        2'b10:   w_rot = {w_clean[2], w_clean[3], w_clean[0], w_clean[1]};
        2'b11:   w_rot = {w_clean[0], w_clean[1], w_clean[3], w_clean[2]};
        default: w_rot = w_clean;
      endcase

      // Opposite-direction cancel.
      w_r = w_rot;
      if (&w_rot[3:2]) w_r[3:2] = 2'b00;
      if (&w_rot[1:0]) w_r[1:0] = 2'b00;

      w_edge = w_r & ~r_prev;

      if (!w_cfg_change) begin
        case (mode)
          2'b00: w_out_next = w_r;
          2'b11: w_out_next = {2'b00, w_r[1:0]};
          2'b01: begin
            // Latest-wins: a fresh press always claims the mask.
            if (dis)                      w_mask_next = 4'b1111;
            else if (|w_edge)             w_mask_next = f_first(w_edge);
            else if (~|(w_r & r_mask))    w_mask_next = 4'b1111;
            else                          w_mask_next = r_mask;
            w_out_next = w_r & w_mask_next;
          end
          default: begin
            // First-wins: the mask is only claimed from the idle state.
            if (dis)                              w_mask_next = 4'b1111;
            else if ((r_mask == 4'b1111) && (|w_r)) w_mask_next = f_first(w_r);
            else if (~|(w_r & r_mask))            w_mask_next = 4'b1111;
            else                                  w_mask_next = r_mask;
            w_out_next = w_r & w_mask_next;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_mask <= 4'b1111;
        r_prev <= 4'b0000;
        r_dir  <= 4'b0000;
        r_chg  <= 1'b0;
      end else begin
        r_mask <= w_mask_next;
        r_prev <= w_r;
        r_dir  <= w_out_next;
        r_chg  <= (w_out_next != r_dir);
      end
    end

    assign dir_out[4*p +: 4] = r_dir;
    assign dir_change[p]     = r_chg;
  end

endmodule
`default_nettype wire
